// File: rtl/uart_rx_8n1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_8n1                                                |
// | Description : Receive-only 8N1 UART. Oversamples the asynchronous rx     |
// |               line with the system clock and recovers one byte per frame.|
// |               A good frame updates rxbyte and pulses rxdone. A low stop   |
// |               bit pulses rxerr, and the receiver then waits for the line  |
// |               to return high.                                            |
// | Ports       : clk     in   system clock, rising edge                      |
// |               rst_n   in   asynchronous active-low reset                  |
// |               rx      in   serial line, idle high, asynchronous to clk    |
// |               rxbyte  out  [7:0] last correctly framed byte              |
// |               rxdone  out  one-cycle strobe when rxbyte is updated       |
// |               rxerr   out  one-cycle strobe on a framing error           |
// |               rxbusy  out  high whenever the receiver is not idle        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxdone,
  output logic       rxerr,
  output logic       rxbusy
);

  localparam int c_HALF = CLKS_PER_BIT / 2;
  localparam int c_CW   = $clog2(CLKS_PER_BIT);

  // Counter terminal values: the start bit is checked half a bit in,
  // every later bit one full bit period after the previous sample.
  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(c_HALF - 1);
  localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_rx_s1;
  logic              r_rx_s2;
  logic [c_CW-1:0]   r_cnt;
  logic [2:0]        r_bitn;
  logic [7:0]        r_sh;
  logic [7:0]        r_rxbyte;
  logic              r_rxdone;
  logic              r_rxerr;
  logic              r_rxbusy;

  // Two-flop synchronizer; reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitn   <= 3'd0;
      r_sh     <= 8'h00;
      r_rxbyte <= 8'h00;
      r_rxdone <= 1'b0;
      r_rxerr  <= 1'b0;
      r_rxbusy <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_rxdone <= 1'b0;
      r_rxerr  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s2) begin
            r_state  <= S_START;
            r_cnt    <= '0;
            r_rxbusy <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == c_HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s2) begin
              r_state <= S_DATA;
              r_bitn  <= 3'd0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              r_state  <= S_IDLE;
              r_rxbusy <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt <= '0;
            // LSB arrives first, so shift in from the top.
            r_sh  <= {r_rx_s2, r_sh[7:1]};
            if (r_bitn == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bitn <= r_bitn + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt <= '0;
            if (r_rx_s2) begin
              r_rxbyte <= r_sh;
              r_rxdone <= 1'b1;
              r_state  <= S_IDLE;
              r_rxbusy <= 1'b0;
            end else begin
              // Keep the previous good byte; wait out the low line.
              r_rxerr <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        S_BREAK: begin
          if (r_rx_s2) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rxbusy <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_rxbusy <= 1'b0;
        end
      endcase
    end
  end

  assign rxbyte = r_rxbyte;
  assign rxdone = r_rxdone;
  assign rxerr  = r_rxerr;
  assign rxbusy = r_rxbusy;

endmodule
`default_nettype wire
